// File: rtl/amp_phase_silencer.sv
// -----------------------------------------------------------------------------
// amp_phase_silencer
//
// Per-transducer slew limiter that sits between the modulation/STM data path
// and the PWM stage. Every frame carries DEPTH (intensity, phase) targets, one
// transducer per beat. For each transducer and channel the output moves
// linearly from where it was to the new target and lands on the target exactly
// after a programmed number of frames. Phase travels the shorter way round the
// 8-bit circle; an exact half-turn goes forward for +128 and backward for -128.
//
// Each output is C = S + floor(k*D/N) mod 256. The division is done exactly by
// an 8-stage restoring divider. The quotient magnitude fits in 8 bits because
// k <= N and |D| <= 255.
//
// Pipeline (LATENCY = 13 cycles from an input beat to its output beat):
//   st1      : per-transducer state read (registered RAM read) + input capture
//   st1->st2 : retarget / step update, state write-back
//   st2->st3 : k*D product
//   st3->st4 : sign / magnitude split
//   st4..st12: restoring divider, one quotient bit per stage
//   st12->out: floor correction, C = S + q, C write-back, output register
// Beat i of the next frame is read at least DEPTH+1 cycles after beat i of
// this frame, so both write-backs land in time as long as DEPTH > LATENCY.
//
// Ports:
//   CLK                         system clock, rising edge
//   RST                         synchronous active-high reset
//   DIN_VALID                   input beat strobe (DEPTH beats per frame)
//   COMPLETION_STEPS_INTENSITY  frames per intensity transition (0 -> 1)
//   COMPLETION_STEPS_PHASE      frames per phase transition (0 -> 1)
//   INTENSITY_IN / PHASE_IN     targets for the current beat
//   BYPASS                      (only with SILENCER_BYPASS_EN) pass-through
//   INTENSITY_OUT / PHASE_OUT   smoothed values for the current output beat
//   DOUT_VALID                  DIN_VALID delayed by LATENCY cycles
//
// Optional feature macro: SILENCER_BYPASS_EN
//   When defined, a BYPASS input is added. While it is high a beat's output
//   equals its input and that transducer's state is left settled at the input.
// -----------------------------------------------------------------------------
module amp_phase_silencer #(
    parameter int DEPTH = 249
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DIN_VALID,
    input  logic [15:0] COMPLETION_STEPS_INTENSITY,
    input  logic [15:0] COMPLETION_STEPS_PHASE,
    input  logic [7:0]  INTENSITY_IN,
    input  logic [7:0]  PHASE_IN,
`ifdef SILENCER_BYPASS_EN
    input  logic        BYPASS,
`endif
    output logic [7:0]  INTENSITY_OUT,
    output logic [7:0]  PHASE_OUT,
    output logic        DOUT_VALID
);

    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LATENCY = 13;

    // Per-transducer transition state: start, target, signed delta,
    // step count and progress.
    typedef struct packed {
        logic [7:0]        s;
        logic [7:0]        t;
        logic signed [8:0] d;
        logic [15:0]       n;
        logic [15:0]       k;
    } chan_st_t;

    // ------------------------------------------------------------------
    // Shared beat bookkeeping: beat counter, valid shift chain, beat index
    // carried alongside the data.
    // ------------------------------------------------------------------
    logic [AW-1:0]    idx_q, idx_d;
    logic [LATENCY:1] v_q, v_d;
    logic [AW-1:0]    a_q [1:LATENCY-1];
    logic [AW-1:0]    a_d [1:LATENCY-1];

    // The state RAMs cannot be cleared in one cycle, so a per-entry "written
    // since reset" flag decides whether the RAM contents or the reset state
    // are used. The flag vector is cleared by reset.
    logic [DEPTH-1:0] seen_q, seen_d;
    logic             seen1_q, seen1_d;

    logic             byp1;

`ifdef SILENCER_BYPASS_EN
    logic byp1_q, byp1_d;

    always_comb begin
        byp1_d = BYPASS;
    end

    always_ff @(posedge CLK) begin
        byp1_q <= byp1_d;
    end

    assign byp1 = byp1_q;
`else
    assign byp1 = 1'b0;
`endif

    always_comb begin
        idx_d = idx_q;
        if (DIN_VALID) begin
            idx_d = (idx_q == AW'(DEPTH - 1)) ? '0 : idx_q + 1'b1;
        end
        v_d    = {v_q[LATENCY-1:1], DIN_VALID};
        a_d[1] = idx_q;
        for (int n = 2; n < LATENCY; n++) begin
            a_d[n] = a_q[n-1];
        end
        seen_d = seen_q;
        if (v_q[1]) begin
            seen_d[a_q[1]] = 1'b1;
        end
        seen1_d = seen_q[idx_q];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q  <= '0;
            v_q    <= '0;
            seen_q <= '0;
        end else begin
            idx_q  <= idx_d;
            v_q    <= v_d;
            seen_q <= seen_d;
        end
        a_q     <= a_d;
        seen1_q <= seen1_d;
    end

    // ------------------------------------------------------------------
    // One identical datapath per channel: gi = 0 intensity, gi = 1 phase.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        localparam bit IS_PHASE = (gi == 1);

        chan_st_t          st_mem [DEPTH];
        logic [7:0]        c_mem  [DEPTH];

        // stage 1
        chan_st_t          st_rd_q;
        logic [7:0]        c_rd_q;
        logic [7:0]        tgt1_q, tgt1_d;
        logic [15:0]       steps1_q, steps1_d;
        chan_st_t          cur, st_d;
        logic [7:0]        cur_c;
        logic signed [9:0] raw;

        // stage 2
        logic [7:0]        s2_q, s2_d;
        logic signed [8:0] d2_q, d2_d;
        logic [15:0]       n2_q, n2_d, k2_q, k2_d;

        // stage 3
        logic [7:0]         s3_q, s3_d;
        logic [15:0]        n3_q, n3_d;
        logic signed [24:0] p3_q, p3_d;
        logic signed [24:0] kx, dx;

        // divider stages: index 0 is stage 4, index 8 is stage 12
        logic [23:0]       r_q   [0:8];
        logic [23:0]       r_d   [0:8];
        logic [7:0]        q_q   [0:8];
        logic [7:0]        q_d   [0:8];
        logic [7:0]        ds_q  [0:8];
        logic [7:0]        ds_d  [0:8];
        logic              neg_q [0:8];
        logic              neg_d [0:8];
        logic [15:0]       dn_q  [0:7];
        logic [15:0]       dn_d  [0:7];

        // output stage
        logic [7:0]        q_fl;
        logic [7:0]        c_fin;
        logic [7:0]        out_q, out_d;

        always_comb begin
            tgt1_d   = IS_PHASE ? PHASE_IN : INTENSITY_IN;
            steps1_d = IS_PHASE ? COMPLETION_STEPS_PHASE : COMPLETION_STEPS_INTENSITY;
        end

        // Stage 1 -> 2: decide whether the target moved, then advance.
        always_comb begin
            cur   = st_rd_q;
            cur_c = c_rd_q;
            if (!seen1_q) begin
                // untouched since reset: settled at zero
                cur.s = '0;
                cur.t = '0;
                cur.d = '0;
                cur.n = 16'd1;
                cur.k = 16'd1;
                cur_c = '0;
            end
            st_d = cur;
            raw  = '0;
            if (byp1) begin
                st_d.s = tgt1_q;
                st_d.t = tgt1_q;
                st_d.d = '0;
                st_d.n = 16'd1;
                st_d.k = 16'd1;
            end else begin
                if (tgt1_q != cur.t) begin
                    // a new transition always starts from the value currently shown
                    raw = $signed({2'b00, tgt1_q}) - $signed({2'b00, cur_c});
                    if (IS_PHASE) begin
                        if (raw > 10'sd128) begin
                            raw = raw - 10'sd256;
                        end else if (raw < -10'sd128) begin
                            raw = raw + 10'sd256;
                        end
                    end
                    st_d.s = cur_c;
                    st_d.t = tgt1_q;
                    st_d.d = raw[8:0];
                    st_d.n = (steps1_q == 16'd0) ? 16'd1 : steps1_q;
                    st_d.k = '0;
                end
                if (st_d.k < st_d.n) begin
                    st_d.k = st_d.k + 16'd1;
                end
            end
            s2_d = st_d.s;
            d2_d = st_d.d;
            n2_d = st_d.n;
            k2_d = st_d.k;
        end

        // Stage 2 -> 3: k*D, at most 65535*255 in magnitude.
        always_comb begin
            kx   = $signed({9'd0, k2_q});
            dx   = {{16{d2_q[8]}}, d2_q};
            p3_d = kx * dx;
            s3_d = s2_q;
            n3_d = n2_q;
        end

        // Stage 3 -> 4 and divider. Long division of |k*D| by N, one quotient
        // bit per stage from the MSB down.
        always_comb begin : div_comb
            logic [24:0] trial;
            r_d[0]   = p3_q[24] ? 24'(-p3_q) : p3_q[23:0];
            q_d[0]   = '0;
            ds_d[0]  = s3_q;
            neg_d[0] = p3_q[24];
            dn_d[0]  = n3_q;
            for (int j = 0; j < 8; j++) begin
                trial      = {1'b0, r_q[j]} - ({9'd0, dn_q[j]} << (7 - j));
                r_d[j+1]   = r_q[j];
                q_d[j+1]   = q_q[j];
                if (!trial[24]) begin
                    r_d[j+1]          = trial[23:0];
                    q_d[j+1][7 - j]   = 1'b1;
                end
                ds_d[j+1]  = ds_q[j];
                neg_d[j+1] = neg_q[j];
            end
            for (int j = 0; j < 7; j++) begin
                dn_d[j+1] = dn_q[j];
            end
        end

        // Output stage: turn the truncated magnitude quotient into a floor
        // and add it to the start value; arithmetic wraps mod 256.
        always_comb begin
            q_fl = q_q[8];
            if (neg_q[8]) begin
                q_fl = 8'd0 - q_q[8] - ((r_q[8] != '0) ? 8'd1 : 8'd0);
            end
            c_fin = ds_q[8] + q_fl;
            out_d = v_q[LATENCY-1] ? c_fin : out_q;
        end

        always_ff @(posedge CLK) begin
            st_rd_q <= st_mem[idx_q];
            c_rd_q  <= c_mem[idx_q];
            if (v_q[1]) begin
                st_mem[a_q[1]] <= st_d;
            end
            if (v_q[LATENCY-1]) begin
                c_mem[a_q[LATENCY-1]] <= c_fin;
            end
        end

        always_ff @(posedge CLK) begin
            tgt1_q   <= tgt1_d;
            steps1_q <= steps1_d;
            s2_q     <= s2_d;
            d2_q     <= d2_d;
            n2_q     <= n2_d;
            k2_q     <= k2_d;
            s3_q     <= s3_d;
            n3_q     <= n3_d;
            p3_q     <= p3_d;
            r_q      <= r_d;
            q_q      <= q_d;
            ds_q     <= ds_d;
            neg_q    <= neg_d;
            dn_q     <= dn_d;
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                out_q <= '0;
            end else begin
                out_q <= out_d;
            end
        end
    end

    assign INTENSITY_OUT = g_ch[0].out_q;
    assign PHASE_OUT     = g_ch[1].out_q;
    assign DOUT_VALID    = v_q[LATENCY];

endmodule

// File: tb/tb_amp_phase_silencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_amp_phase_silencer
//
// Scoreboard bench. The driver computes each beat's expected output with a
// behavioural model (plain integer arithmetic on per-transducer S/T/D/N/k/C)
// and queues it; an independent monitor pops an entry for every DOUT_VALID
// beat and compares. Directed runs additionally carry hand-worked values for
// transducer 0, and settle trials require every output to equal its target on
// the final frame.
// -----------------------------------------------------------------------------
module tb_amp_phase_silencer;

    localparam int DEPTH = 249;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic [15:0] steps_i = '0;
    logic [15:0] steps_p = '0;
    logic [7:0]  in_i = '0;
    logic [7:0]  in_p = '0;
    logic [7:0]  out_i;
    logic [7:0]  out_p;
    logic        dout_valid;
`ifdef SILENCER_BYPASS_EN
    logic        bypass = 1'b0;
`endif

    amp_phase_silencer #(.DEPTH(DEPTH)) dut (
        .CLK                        (clk),
        .RST                        (rst),
        .DIN_VALID                  (din_valid),
        .COMPLETION_STEPS_INTENSITY (steps_i),
        .COMPLETION_STEPS_PHASE     (steps_p),
        .INTENSITY_IN               (in_i),
        .PHASE_IN                   (in_p),
`ifdef SILENCER_BYPASS_EN
        .BYPASS                     (bypass),
`endif
        .INTENSITY_OUT              (out_i),
        .PHASE_OUT                  (out_p),
        .DOUT_VALID                 (dout_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ei;
        int ep;
        bit plan;
        int pi;
        int pp;
        int issue;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   first_lat = -1;
    int   frame_no = 0;

    // behavioural model state, [channel][transducer]
    int m_s [2][DEPTH];
    int m_t [2][DEPTH];
    int m_d [2][DEPTH];
    int m_n [2][DEPTH];
    int m_k [2][DEPTH];
    int m_c [2][DEPTH];

    int tgt_i [DEPTH];
    int tgt_p [DEPTH];

    // hand-worked sequences for transducer 0
    int p_a   [11] = '{21, 33, 45, 57, 69, 80, 92, 104, 116, 128, 128};
    int p_bi  [11] = '{25, 51, 76, 102, 127, 153, 178, 204, 229, 255, 255};
    int p_bp  [11] = '{12, 25, 38, 51, 64, 76, 89, 102, 115, 128, 128};
    int p_dn  [11] = '{254, 253, 252, 251, 250, 249, 248, 247, 246, 245, 245};
    int p_w1  [11] = '{253, 240, 227, 215, 202, 189, 177, 164, 151, 139, 139};
    int p_w2  [11] = '{242, 229, 216, 203, 191, 178, 165, 152, 139, 127, 127};
    int p_w3  [11] = '{11, 24, 37, 49, 62, 75, 87, 100, 113, 126, 126};
    int p_z1  [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 10};
    int p_z2  [11] = '{187, 195, 202, 210, 218, 225, 233, 240, 248, 0, 0};
    int p_sm  [11] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_s[ch][i] = 0;
                m_t[ch][i] = 0;
                m_d[ch][i] = 0;
                m_n[ch][i] = 1;
                m_k[ch][i] = 1;
                m_c[ch][i] = 0;
            end
        end
    endfunction

    // C = S + floor(k*D/N) mod 256, phase delta folded onto the short arc
    function automatic int model_step(input int ch, input int i, input int tgt, input int steps);
        int kd;
        int q;
        if (tgt != m_t[ch][i]) begin
            m_s[ch][i] = m_c[ch][i];
            m_t[ch][i] = tgt;
            m_n[ch][i] = (steps == 0) ? 1 : steps;
            m_k[ch][i] = 0;
            m_d[ch][i] = tgt - m_s[ch][i];
            if (ch == 1) begin
                if (m_d[ch][i] > 128) m_d[ch][i] -= 256;
                else if (m_d[ch][i] < -128) m_d[ch][i] += 256;
            end
        end
        if (m_k[ch][i] < m_n[ch][i]) m_k[ch][i]++;
        kd = m_k[ch][i] * m_d[ch][i];
        q  = kd / m_n[ch][i];
        if ((kd % m_n[ch][i]) != 0 && kd < 0) q--;
        m_c[ch][i] = (((m_s[ch][i] + q) % 256) + 256) % 256;
        return m_c[ch][i];
    endfunction

    // monitor: one scoreboard entry per output beat
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (dout_valid) begin
            if (sb.size() == 0) begin
                check("dout_with_empty_queue", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("intensity", int'(out_i), e.ei);
                check("phase", int'(out_p), e.ep);
                if (e.plan) begin
                    check("plan_intensity", int'(out_i), e.pi);
                    check("plan_phase", int'(out_p), e.pp);
                end
                lat = cyc - e.issue;
                if (first_lat < 0) begin
                    first_lat = lat;
                    check("latency_in_bounds", int'(lat <= 32 && lat < DEPTH), 1);
                end else begin
                    check("latency_constant", lat, first_lat);
                end
            end
        end
    end

    task automatic set_all(input int a, input int p);
        for (int b = 0; b < DEPTH; b++) begin
            tgt_i[b] = a;
            tgt_p[b] = p;
        end
    endtask

    // plan_mode: 0 none, 1 beat 0 against (p0i,p0p), 2 every beat against its target
    task automatic send_frame(input int si, input int sp, input int plan_mode,
                              input int p0i, input int p0p, input int nbeats);
        exp_t e;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            din_valid = 1'b1;
            in_i      = 8'(tgt_i[b]);
            in_p      = 8'(tgt_p[b]);
            steps_i   = 16'(si);
            steps_p   = 16'(sp);
            e.ei      = model_step(0, b, tgt_i[b], si);
            e.ep      = model_step(1, b, tgt_p[b], sp);
            e.plan    = (plan_mode == 2) || (plan_mode == 1 && b == 0);
            e.pi      = (plan_mode == 2) ? tgt_i[b] : p0i;
            e.pp      = (plan_mode == 2) ? tgt_p[b] : p0p;
            e.issue   = cyc;
            sb.push_back(e);
        end
        $display("frame %0d: %0d beats, steps %0d/%0d, beat0 target (%0d,%0d) model (%0d,%0d)",
                 frame_no, nbeats, si, sp, tgt_i[0], tgt_p[0], m_c[0][0], m_c[1][0]);
        frame_no++;
        if (nbeats == DEPTH) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                din_valid = 1'b0;
                in_i      = 8'($urandom);
                in_p      = 8'($urandom);
                steps_i   = 16'($urandom);
                steps_p   = 16'($urandom);
            end
        end
    endtask

    task automatic directed(input int si, input int sp, input int ti, input int tp,
                            input int pli [11], input int plp [11]);
        set_all(si, sp);
        send_frame(1, 1, 0, 0, 0, DEPTH);
        set_all(ti, tp);
        for (int f = 0; f < 11; f++) begin
            send_frame(10, 10, 1, pli[f], plp[f], DEPTH);
        end
    endtask

    task automatic settle_trial(input int nsteps);
        for (int b = 0; b < DEPTH; b++) begin
            tgt_i[b] = $urandom_range(0, 255);
            tgt_p[b] = $urandom_range(0, 255);
        end
        send_frame(1, 1, 0, 0, 0, DEPTH);
        for (int b = 0; b < DEPTH; b++) begin
            tgt_i[b] = (tgt_i[b] + $urandom_range(1, 255)) % 256;
            tgt_p[b] = (tgt_p[b] + $urandom_range(1, 255)) % 256;
        end
        for (int f = 1; f <= nsteps; f++) begin
            // steps inputs after the first frame must not disturb the transition
            if (f == 1) send_frame(nsteps, nsteps, 0, 0, 0, DEPTH);
            else send_frame($urandom_range(1, 255), $urandom_range(1, 255),
                            (f == nsteps) ? 2 : 0, 0, 0, DEPTH);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_dout_valid", int'(dout_valid), 0);
        check("reset_intensity", int'(out_i), 0);
        check("reset_phase", int'(out_p), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        directed(10, 10, 128, 128, p_a, p_a);
        directed(0, 0, 255, 128, p_bi, p_bp);
        directed(255, 10, 245, 139, p_dn, p_w1);
        directed(255, 255, 245, 127, p_dn, p_w2);
        directed(255, 255, 245, 126, p_dn, p_w3);
        directed(255, 255, 245, 10, p_dn, p_z1);
        directed(255, 180, 245, 0, p_dn, p_z2);
        directed(0, 0, 5, 5, p_sm, p_sm);

        // random retargeting, including mid-transition changes and steps = 0
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < DEPTH; b++) begin
                if ($urandom_range(0, 1) == 1) tgt_i[b] = $urandom_range(0, 255);
                if ($urandom_range(0, 1) == 1) tgt_p[b] = $urandom_range(0, 255);
            end
            send_frame($urandom_range(0, 12), $urandom_range(0, 12), 0, 0, 0, DEPTH);
        end

        settle_trial($urandom_range(1, 24));
        settle_trial($urandom_range(1, 24));

        // reset in the middle of a frame
        for (int b = 0; b < DEPTH; b++) begin
            tgt_i[b] = $urandom_range(1, 255);
            tgt_p[b] = $urandom_range(1, 255);
        end
        send_frame(4, 4, 0, 0, 0, 100);
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        check("midreset_dout_valid", int'(dout_valid), 0);
        check("midreset_intensity", int'(out_i), 0);
        check("midreset_phase", int'(out_p), 0);
        sb.delete();
        model_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("postreset_idle_dout_valid", int'(dout_valid), 0);

        // the next frames must start at beat 0 from the cleared state
        for (int f = 0; f < 3; f++) begin
            send_frame(8, 3, 0, 0, 0, DEPTH);
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
